pmod_da2_serializer: RTL and testbench
======================================

// Module: pmod_da2_serializer
// PURPOSE
//  Frame generator and shifter for the Digilent PMOD-DA2, which carries two DAC121S101 converters.
//  Takes 32-bit stereo words {L[15:0], R[15:0]} (signed PCM) over a valid/ready handshake in the
//  clk_selected domain. Drives SYNC/DINA/DINB/SCLK on the 4 PMOD data pins.
//  Sits downstream of the FIFO-to-sample-clock fetch stage; the CDC is done upstream.
// PARAMETERS
//  DIV_WIDTH  4   width of the sclk_div input
//  GAP_BITS   16  SCLK periods with SYNC high after each 16-bit frame (frame = 16+GAP_BITS periods)
//  UR_WIDTH   8   width of the saturating underrun counter
// PORTS
//  clk_selected   in   1          audio master clock (custom_clk0/custom_clk1 mux output)
//  reset          in   1          asynchronous, active-high
//  enable         in   1          run frames; sampled only at frame boundaries
//  sclk_div       in   DIV_WIDTH  SCLK half-period in clk_selected cycles, minus 1
//  sample_data    in   32         {left[15:0], right[15:0]}, two's complement
//  sample_valid   in   1          upstream has a word
//  sample_ready   out  1          1-cycle pulse at frame start; transfer = valid & ready
//  pmod_io        out  4          [0]=SYNC (active low), [1]=DINA (left), [2]=DINB (right), [3]=SCLK
//  frame_strobe   out  1          1-cycle pulse in the cycle the frame starts (both load and reload)
//  underrun_count out  UR_WIDTH   frames started with no valid word; saturates at all-ones
// BEHAVIOUR
//  Reset (async) values:
//  - pmod_io=4'b0001 (SYNC high, SCLK/DIN low).
//  - sample_ready=0, frame_strobe=0, underrun_count=0.
//  - Hold and shift registers = midscale (12'h800 per channel). FSM=IDLE.
//  Tick divider: counts 0..div_latched; 'tick' on reaching div_latched, then wraps to 0.
//  - div_latched is loaded from sclk_div at reset release and at each frame start.
//  - sclk_div=0 gives a tick every cycle, i.e. SCLK = clk_selected/2.
//  SCLK toggles on every tick while in SHIFT/GAP; rise-tick = tick while SCLK=0, fall-tick otherwise.
//  The DAC captures DIN on the SCLK falling edge. DIN/SYNC change only on rise-ticks.
//  Word per channel: {2'b00, PD=2'b00, code[11:0]} MSB first, code = {~s[15], s[14:4]}
//  (signed to offset binary, truncating the low 4 bits).
//  FSM:
//  - IDLE:
//    - SCLK low, SYNC high.
//    - On tick with enable=1 -> START.
//  - START (exactly 1 cycle):
//    - sample_ready=1 and frame_strobe=1.
//    - If sample_valid: hold <- converted words.
//    - Else: hold unchanged; underrun_count++ (saturating).
//    - Shift registers <- hold value (new if loaded). bit_cnt=0.
//    - Go to SHIFT; the next rise-tick drives SYNC low with bit 15 on DIN.
//  - SHIFT:
//    - Each rise-tick presents the next bit; after the 16th falling edge -> GAP.
//    - At that point the next rise-tick drives SYNC high and DIN 0.
//  - GAP:
//    - Counts GAP_BITS SCLK periods.
//    - On the final fall-tick: if enable -> START, else -> IDLE (SCLK left low).
//  Frame period = (16+GAP_BITS)*2*(sclk_div+1) clk_selected cycles; no START is skipped while enabled.
//  Boundary conditions:
//  - enable drop mid-frame: the current frame completes.
//  - sclk_div change mid-frame: ignored until the next START.
//  - sample_valid held high between STARTs: no transfer (ready low).
//  - Reset mid-frame: immediate return to reset values; no partial-frame resume.
//  - underrun_count at max: stays at max. It is cleared only by reset.
//  - All outputs registered; pmod_io never glitches.
// STRUCTURE
//  Shared package pmod_pkg:
//  - DAC121_FRAME_BITS=16, DAC121_PD_NORMAL=2'b00, DAC_MIDSCALE=12'h800.
//  - FSM state encoding.
//  - Function pcm16_to_offset12().
//  Sub-module sclk_tick_gen (divider + SCLK toggle, tick/rise/fall outputs).
//  The FSM and shifters stay in this module.
// TESTING
//  1. sclk_div=0, GAP_BITS=16, valid always, word 32'h7FFF_8000:
//     - DINA shifts 16'h0FFF, DINB 16'h0000 on falling edges.
//     - SYNC low exactly 16 SCLK periods; frame period 64 clk_selected cycles.
//  2. Word 32'h0000_FFF0:
//     - DINA=16'h0800, DINB=16'h07FF.
//     - One ready pulse per frame; frame_strobe coincident with it.
//  3. sample_valid low for 3 frames:
//     - Last word repeated 3 times; underrun_count 0->3.
//     - Valid again: new word loads and the count holds at 3.
//  4. sclk_div changed 1->3 mid-frame:
//     - Current frame keeps a 4-cycle SCLK period.
//     - Next frame uses an 8-cycle period; SCLK duty stays 50%.
//  5. enable dropped at bit 5:
//     - Frame finishes, GAP completes.
//     - Outputs settle to 4'b0001; no further ready pulse.
//  6. Reset asserted at bit 9, asynchronous to the clock edge:
//     - pmod_io=4'b0001 at once; underrun_count=0.
//     - After release with enable=1, the first frame is midscale if no valid word is present.

Source files
------------

// File: rtl/pmod_pkg.sv
// Shared definitions for the PMOD-DA2 (dual DAC121S101) serializer.
//   DAC121_FRAME_BITS : SCLK periods per DAC word
//   DAC121_PD_NORMAL  : power-down field for normal operation
//   DAC_MIDSCALE      : 12-bit midscale code
//   dac_state_t       : serializer FSM states
//   pcm16_to_offset12 : signed PCM16 -> 16-bit DAC word (offset binary, low 4 bits dropped)
package pmod_pkg;

  localparam int          DAC121_FRAME_BITS = 16;
  localparam logic [1:0]  DAC121_PD_NORMAL  = 2'b00;
  localparam logic [11:0] DAC_MIDSCALE      = 12'h800;
  localparam logic [15:0] DAC_MIDSCALE_WORD = {2'b00, DAC121_PD_NORMAL, DAC_MIDSCALE};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_GAP
  } dac_state_t;

  function automatic logic [15:0] pcm16_to_offset12(input logic [15:0] s);
    return {2'b00, DAC121_PD_NORMAL, ~s[15], s[14:4]};
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK tick divider and SCLK toggle register.
//   clk_selected in  : clock
//   reset        in  : asynchronous, active-high
//   load         in  : frame start; latches sclk_div (also done on the first cycle after reset)
//   run          in  : SCLK toggles on ticks while high
//   sclk_div     in  : SCLK half-period in clock cycles, minus 1
//   tick         out : counter reached the latched divisor
//   rise / fall  out : tick while SCLK is low / high
//   sclk         out : registered SCLK
module sclk_tick_gen #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk_selected,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] sclk_div,
  output logic                 tick,
  output logic                 rise,
  output logic                 fall,
  output logic                 sclk
);

  logic                 fresh;
  logic [DIV_WIDTH-1:0] div_latched;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_eff;

  // The counter is always 0 on a load cycle, so comparing against the
  // incoming divisor there makes the new frame's first half-period exact.
  assign div_eff = (load || fresh) ? sclk_div : div_latched;
  assign tick    = (cnt == div_eff);
  assign rise    = tick & ~sclk;
  assign fall    = tick & sclk;

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      fresh       <= 1'b1;
      div_latched <= '0;
      cnt         <= '0;
      sclk        <= 1'b0;
    end else begin
      fresh <= 1'b0;
      if (load || fresh) div_latched <= sclk_div;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && run) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/pmod_da2_serializer.sv
// PMOD-DA2 frame generator: converts stereo PCM16 words to two DAC121S101
// serial streams sharing SYNC and SCLK.
//   clk_selected   in  : audio master clock
//   reset          in  : asynchronous, active-high
//   enable         in  : run frames (sampled at frame boundaries)
//   sclk_div       in  : SCLK half-period in clock cycles, minus 1
//   sample_data    in  : {left[15:0], right[15:0]} two's complement
//   sample_valid   in  : upstream word available
//   sample_ready   out : 1-cycle pulse at frame start
//   pmod_io        out : [0]=SYNC_n [1]=DINA [2]=DINB [3]=SCLK
//   frame_strobe   out : 1-cycle pulse at frame start
//   underrun_count out : saturating count of frames started without a word
module pmod_da2_serializer
  import pmod_pkg::*;
#(
  parameter int DIV_WIDTH = 4,
  parameter int GAP_BITS  = 16,
  parameter int UR_WIDTH  = 8
) (
  input  logic                 clk_selected,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] sclk_div,
  input  logic [31:0]          sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [3:0]           pmod_io,
  output logic                 frame_strobe,
  output logic [UR_WIDTH-1:0]  underrun_count
);

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  dac_state_t    state;
  logic [15:0]   hold_a, hold_b;
  logic [15:0]   sh_a, sh_b;
  logic [15:0]   word_a, word_b;
  logic          sync, din_a, din_b;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          tick, rise, fall, sclk;
  logic          load, run;

  assign load    = (state == ST_START);
  assign run     = (state != ST_IDLE);
  assign pmod_io = {sclk, din_b, din_a, sync};

  sclk_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk_selected(clk_selected),
    .reset       (reset),
    .load        (load),
    .run         (run),
    .sclk_div    (sclk_div),
    .tick        (tick),
    .rise        (rise),
    .fall        (fall),
    .sclk        (sclk)
  );

  always_comb begin
    word_a = hold_a;
    word_b = hold_b;
    if (sample_valid) begin
      word_a = pcm16_to_offset12(sample_data[31:16]);
      word_b = pcm16_to_offset12(sample_data[15:0]);
    end
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      hold_a         <= DAC_MIDSCALE_WORD;
      hold_b         <= DAC_MIDSCALE_WORD;
      sh_a           <= DAC_MIDSCALE_WORD;
      sh_b           <= DAC_MIDSCALE_WORD;
      sync           <= 1'b1;
      din_a          <= 1'b0;
      din_b          <= 1'b0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      sample_ready   <= 1'b0;
      frame_strobe   <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_ready <= 1'b0;
      frame_strobe <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tick && enable) begin
            state        <= ST_START;
            sample_ready <= 1'b1;
            frame_strobe <= 1'b1;
          end
        end
        ST_START: begin
          hold_a <= word_a;
          hold_b <= word_b;
          if (!sample_valid && underrun_count != '1)
            underrun_count <= underrun_count + 1'b1;
          // With sclk_div=0 the first rise-tick lands in this cycle, so the
          // first bit is presented straight from the freshly selected word.
          if (rise) begin
            sync    <= 1'b0;
            din_a   <= word_a[15];
            din_b   <= word_b[15];
            sh_a    <= {word_a[14:0], 1'b0};
            sh_b    <= {word_b[14:0], 1'b0};
            bit_cnt <= 5'd1;
          end else begin
            sh_a    <= word_a;
            sh_b    <= word_b;
            bit_cnt <= '0;
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rise) begin
            sync    <= 1'b0;
            din_a   <= sh_a[15];
            din_b   <= sh_b[15];
            sh_a    <= {sh_a[14:0], 1'b0};
            sh_b    <= {sh_b[14:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (fall && bit_cnt == 5'(DAC121_FRAME_BITS)) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (rise) begin
            sync  <= 1'b1;
            din_a <= 1'b0;
            din_b <= 1'b0;
          end else if (fall) begin
            if (gap_cnt == GW'(GAP_BITS - 1)) begin
              if (enable) begin
                state        <= ST_START;
                sample_ready <= 1'b1;
                frame_strobe <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_da2_serializer.sv
module tb_pmod_da2_serializer;

  logic        clk_selected = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  sclk_div;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  pmod_io;
  logic        frame_strobe;
  logic [7:0]  underrun_count;

  always #5 clk_selected = ~clk_selected;

  pmod_da2_serializer #(
    .DIV_WIDTH(4),
    .GAP_BITS (16),
    .UR_WIDTH (8)
  ) dut (
    .clk_selected  (clk_selected),
    .reset         (reset),
    .enable        (enable),
    .sclk_div      (sclk_div),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .pmod_io       (pmod_io),
    .frame_strobe  (frame_strobe),
    .underrun_count(underrun_count)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          half;
    int          period;
    int          ur;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ready_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: reassembles serial frames on SCLK falling edges and checks them
  // against the scoreboard; also checks strobe/ready pairing and frame period.
  int          cyc = 0;
  int          run_len = 0;
  int          nbits = 0;
  int          last_strobe = 0;
  int          prev_period = 0;
  int          cur_half;
  logic [15:0] acc_a = '0, acc_b = '0;
  logic        bad = 1'b0;
  logic        p_sclk = 1'b0, p_sync = 1'b1, p_a = 1'b0, p_b = 1'b0;
  exp_t        e;

  always @(negedge clk_selected) begin
    cyc++;
    if (reset) begin
      nbits       = 0;
      bad         = 1'b0;
      prev_period = 0;
      run_len     = 0;
    end else begin
      if (frame_strobe || sample_ready) begin
        check("ready_with_strobe", {30'd0, frame_strobe, sample_ready}, 32'd3);
        if (sample_ready) ready_pulses++;
        if (frame_strobe) begin
          if (prev_period != 0) check("frame_period", cyc - last_strobe, prev_period);
          prev_period = 0;
          last_strobe = cyc;
        end
      end
      cur_half = (sb.size() > 0) ? sb[0].half : 0;
      if (pmod_io[3] != p_sclk) begin
        if (!pmod_io[3] && !p_sync) begin
          if (run_len != cur_half) bad = 1'b1;
          acc_a = {acc_a[14:0], p_a};
          acc_b = {acc_b[14:0], p_b};
          nbits++;
          if (nbits == 16) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty: frame %h/%h with no expectation", acc_a, acc_b);
            end else begin
              e = sb.pop_front();
              check("dina_word", acc_a, e.a);
              check("dinb_word", acc_b, e.b);
              check("underrun_count", underrun_count, e.ur);
              check("sclk_half_ok", bad, 0);
              prev_period = e.period;
            end
            bad = 1'b0;
          end
        end else if (pmod_io[3] && !p_sync) begin
          if (run_len != cur_half && nbits != 16) bad = 1'b1;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      if (pmod_io[0] && !p_sync) begin
        check("sync_low_periods", nbits, 16);
        nbits = 0;
      end
    end
    p_sclk = pmod_io[3];
    p_sync = pmod_io[0];
    p_a    = pmod_io[1];
    p_b    = pmod_io[2];
  end

  // Present a word, wait for the frame it lands in, then queue the expectation.
  task automatic run_frame(input logic [31:0] d, input logic v, input logic [15:0] ea,
                           input logic [15:0] eb, input int half, input int period, input int ur);
    bit   found = 0;
    exp_t x;
    sample_data  = d;
    sample_valid = v;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_selected);
      if (frame_strobe) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: got no strobe expected strobe within 4000 cycles");
      return;
    end
    @(posedge clk_selected);
    #1;
    x.a = ea; x.b = eb; x.half = half; x.period = period; x.ur = ur;
    sb.push_back(x);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sclk_div     = 4'd0;
    sample_data  = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk_selected);
    #1;
    check("reset_pmod_io", pmod_io, 4'b0001);
    check("reset_ready", sample_ready, 0);
    check("reset_strobe", frame_strobe, 0);
    check("reset_underrun", underrun_count, 0);

    enable = 1'b1;
    @(negedge clk_selected);
    reset = 1'b0;

    // Full-scale words, fastest SCLK
    run_frame(32'h7FFF_8000, 1'b1, 16'h0FFF, 16'h0000, 1, 64, 0);
    run_frame(32'h7FFF_8000, 1'b1, 16'h0FFF, 16'h0000, 1, 64, 0);
    run_frame(32'h7FFF_8000, 1'b1, 16'h0FFF, 16'h0000, 1, 64, 0);
    // Zero and -16
    run_frame(32'h0000_FFF0, 1'b1, 16'h0800, 16'h07FF, 1, 64, 0);
    // Underruns repeat the last word
    run_frame(32'hDEAD_BEEF, 1'b0, 16'h0800, 16'h07FF, 1, 64, 1);
    run_frame(32'hDEAD_BEEF, 1'b0, 16'h0800, 16'h07FF, 1, 64, 2);
    run_frame(32'hDEAD_BEEF, 1'b0, 16'h0800, 16'h07FF, 1, 64, 3);
    run_frame(32'h1234_5678, 1'b1, 16'h0923, 16'h0D67, 1, 64, 3);
    // Divider changes apply at the next frame start only
    sclk_div = 4'd1;
    run_frame(32'h0000_FFF0, 1'b1, 16'h0800, 16'h07FF, 2, 128, 3);
    repeat (30) @(posedge clk_selected);
    #1;
    sclk_div = 4'd3;
    run_frame(32'h7FFF_8000, 1'b1, 16'h0FFF, 16'h0000, 4, 256, 3);
    sclk_div = 4'd0;
    // Enable dropped mid-frame
    run_frame(32'h1234_5678, 1'b1, 16'h0923, 16'h0D67, 1, 0, 3);
    repeat (8) @(posedge clk_selected);
    #1;
    enable = 1'b0;
    repeat (150) @(posedge clk_selected);
    #1;
    check("idle_pmod_io", pmod_io, 4'b0001);
    repeat (200) @(posedge clk_selected);
    #1;
    check("ready_pulses_after_disable", ready_pulses, 11);
    check("idle_pmod_io_late", pmod_io, 4'b0001);

    // Asynchronous reset mid-frame
    enable = 1'b1;
    run_frame(32'h7FFF_8000, 1'b1, 16'h0FFF, 16'h0000, 1, 0, 3);
    sample_valid = 1'b0;
    repeat (18) @(posedge clk_selected);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_pmod_io", pmod_io, 4'b0001);
    check("async_reset_underrun", underrun_count, 0);
    check("async_reset_ready", sample_ready, 0);
    sb.delete();
    repeat (2) @(negedge clk_selected);
    #2;
    reset = 1'b0;
    run_frame(32'h7FFF_8000, 1'b0, 16'h0800, 16'h0800, 1, 64, 1);
    run_frame(32'h0000_FFF0, 1'b1, 16'h0800, 16'h07FF, 1, 0, 1);
    enable = 1'b0;

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk_selected);
    check("scoreboard_drained", sb.size(), 0);
    check("ready_pulses_total", ready_pulses, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
